uart_axil_regs: RTL and testbench
=================================

Name: uart_axil_regs

Overview:
- AXI4-Lite slave register bridge that drives the host side of uart_top.
- Converts bus reads and writes into the uart_top handshake: read_uart/write_uart pulses, write_data, br_limit_in.
- Also exposes FIFO status and the baud limit as registers.
- Sits between the system interconnect and uart_top; it is the bus-facing end of the UART's local FIFO interface.

Parameters:
- ADDR_W, 5, AXI address width; only addr[4:2] is decoded.
- DBITS, 8, UART data width; must match uart_top.
- BAUD_DEFAULT, 651, reset value of the baud limit (9600 baud at 100 MHz).

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- s_awaddr  in  ADDR_W; s_awvalid in 1; s_awready out 1 — AXI write address channel.
- s_wdata  in  32; s_wstrb in 4; s_wvalid in 1; s_wready out 1 — AXI write data channel.
- s_bresp  out  2; s_bvalid out 1; s_bready in 1 — AXI write response channel.
- s_araddr  in  ADDR_W; s_arvalid in 1; s_arready out 1 — AXI read address channel.
- s_rdata  out  32; s_rresp out 2; s_rvalid out 1; s_rready in 1 — AXI read data channel.
- rx_empty  in  1; rx_full in 1; tx_full in 1 — uart_top FIFO flags.
- read_data  in  DBITS — RX FIFO head (first-word-fall-through).
- read_uart  out  1 — RX pop pulse.
- write_uart  out  1 — TX push pulse.
- write_data  out  DBITS — TX byte.
- br_limit_in  out  16 — baud counter limit M.
- irq  out  1 — interrupt.

Behaviour:
- Register map (offset from addr[4:2]):
  - 0x00 RX_DATA (RO): [7:0] head byte, [8] empty-at-read flag.
  - 0x04 TX_DATA (WO): [7:0] byte to transmit.
  - 0x08 STATUS: [0] rx_empty, [1] rx_full, [2] tx_full, [3] tx_drop (sticky; write 1 to clear).
  - 0x0C BAUD (RW): [15:0] limit.
  - 0x10 IRQ_EN: present only with the macro.
  - Any other offset: SLVERR (2'b10); reads return 0.
- Reset values:
  - All ready and valid outputs 0; bresp/rresp 0; rdata 0.
  - read_uart, write_uart, write_data, irq all 0.
  - br_limit_in = BAUD_DEFAULT; tx_drop = 0.
  - Any in-flight transaction is discarded and both FSMs return to IDLE.
- Write FSM (WR_IDLE, WR_RESP):
  - In WR_IDLE, awready = ~aw_held and wready = ~w_held. AW and W are latched independently, in either order or the same cycle.
  - When both are held, the write commits that cycle, bvalid rises the next cycle, and the FSM enters WR_RESP.
  - WR_RESP holds bvalid until bready, then returns to WR_IDLE and clears both held flags.
  - One write outstanding at a time.
- Write effects:
  - TX_DATA with wstrb[0] and ~tx_full: write_data = wdata[7:0] and write_uart = 1 for exactly 1 cycle, both registered, on the cycle after commit.
  - TX_DATA with tx_full: byte dropped, tx_drop set, bresp SLVERR.
  - TX_DATA with wstrb[0]=0: no push, OKAY.
  - BAUD: bytes updated per wstrb[1:0].
  - STATUS: only bit 3 is write-1-to-clear; other bits ignored.
  - Write to RX_DATA: SLVERR, no effect.
- Read FSM (RD_IDLE, RD_DATA):
  - RD_IDLE: arready = 1. On arvalid, the register value is captured into rdata and the FSM enters RD_DATA with rvalid = 1 the next cycle.
  - RD_DATA holds rvalid and rdata stable until rready.
  - Read latency: 1 cycle from the AR handshake to rvalid.
- RX_DATA read:
  - If ~rx_empty: rdata = {23'b0, 1'b0, read_data}, and read_uart pulses for 1 cycle in the cycle after the AR handshake.
  - If rx_empty: rdata = 0x100, no pop, OKAY.
  - A stalled rready never causes a second pop.
- Simultaneous events:
  - Read and write FSMs are independent and may both commit in the same cycle.
  - Read of BAUD in the same cycle as a BAUD write returns the old value.
  - tx_drop set and W1C clear in the same cycle: set wins.
- Without the macro, irq = 0.

Optional Feature:
- Macro: UART_AXIL_IRQ_EN.
- Defined:
  - IRQ_EN register at 0x10 (RW, reset 0): [0] rx-not-empty enable, [1] tx-not-full enable.
  - irq registered: irq <= (en0 & ~rx_empty) | (en1 & ~tx_full); 1-cycle latency.
- Undefined: offset 0x10 decodes as unmapped (SLVERR); irq tied to 0.

Decomposition:
- Package uart_axil_pkg holds:
  - Register offset constants (RX_DATA, TX_DATA, STATUS, BAUD, IRQ_EN).
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - STATUS bit indices.
  - Read and write state encodings.
- No sub-module: both channel FSMs and the register file stay in one module.

Test Plan:
- Reset, then read BAUD -> rdata 0x0000028B, rresp 0; irq 0.
- Write 0x55 to TX_DATA, with AW 3 cycles before W, tx_full 0 -> write_uart pulses once with write_data 0x55; bresp 0.
- tx_full 1, write 0xAA to TX_DATA -> no write_uart; bresp SLVERR.
  - Then STATUS reads 0x8 | flags.
  - Write 0x8 to STATUS -> bit 3 clears.
- rx_empty 0, read_data 0x3C, read RX_DATA with rready held low 5 cycles:
  - rdata 0x3C stable throughout; exactly one read_uart pulse.
  - Repeat with rx_empty 1 -> rdata 0x100, no pulse.
- Write 0x0034 to BAUD with wstrb 0x1 -> br_limit_in 0x0234.
- Read 0x14 -> rresp SLVERR, rdata 0.
- Assert reset while bvalid is pending -> bvalid 0 next cycle; br_limit_in 651.
- With UART_AXIL_IRQ_EN: IRQ_EN = 1, rx_empty falls -> irq 1 one cycle later.

Source files
------------

// File: rtl/uart_axil_pkg.sv
// Shared register map, response codes and FSM encodings for the uart_axil_regs bridge.
package uart_axil_pkg;

    // Word indices taken from addr[4:2]
    localparam logic [2:0] REG_RX_DATA = 3'd0;
    localparam logic [2:0] REG_TX_DATA = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_BAUD    = 3'd3;
    localparam logic [2:0] REG_IRQ_EN  = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ST_RX_EMPTY = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_TX_FULL  = 2;
    localparam int ST_TX_DROP  = 3;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    function automatic logic [15:0] merge_bytes16(input logic [15:0] old_v,
                                                  input logic [15:0] new_v,
                                                  input logic [1:0]  strb);
        merge_bytes16 = {strb[1] ? new_v[15:8] : old_v[15:8],
                         strb[0] ? new_v[7:0]  : old_v[7:0]};
    endfunction

endpackage

// File: rtl/uart_axil_regs_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and uart_axil_regs (slave).
interface uart_axil_regs_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/uart_axil_regs.sv
// AXI4-Lite register bridge for the host side of uart_top.
// Define UART_AXIL_IRQ_EN to add the IRQ_EN register at 0x10 and a live irq output.
module uart_axil_regs
    import uart_axil_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int DBITS        = 8,
    parameter int BAUD_DEFAULT = 651
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    uart_axil_regs_if.slave   s_axi,
    input  logic              rx_empty,
    input  logic              rx_full,
    input  logic              tx_full,
    input  logic [DBITS-1:0]  read_data,
    output logic              read_uart,
    output logic              write_uart,
    output logic [DBITS-1:0]  write_data,
    output logic [15:0]       br_limit_in,
    output logic              irq
);

    wr_state_t         r_wr_state;
    wr_state_t         w_wr_next;
    rd_state_t         r_rd_state;
    rd_state_t         w_rd_next;

    logic              r_aw_held;
    logic              r_w_held;
    logic [2:0]        r_aw_idx;
    logic [15:0]       r_wdata;
    logic [1:0]        r_wstrb;
    logic [1:0]        r_bresp;

    logic              r_tx_drop;
    logic [15:0]       r_baud;
    logic              r_write_uart;
    logic [DBITS-1:0]  r_write_data;

    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;
    logic              r_read_uart;

    logic [ADDR_W-1:0] w_awaddr;
    logic [ADDR_W-1:0] w_araddr;
    logic              w_awready;
    logic              w_wready;
    logic              w_bvalid;
    logic              w_arready;
    logic              w_rvalid;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_b_hs;
    logic              w_ar_hs;
    logic              w_commit;

    logic [1:0]        w_wr_resp;
    logic              w_push;
    logic              w_drop;
    logic              w_drop_clr;
    logic              w_baud_we;
    logic              w_irqen_we;

    logic [31:0]       w_status;
    logic [31:0]       w_rd_val;
    logic [1:0]        w_rd_resp;
    logic              w_pop;
    logic [1:0]        w_irq_en;
    logic              w_unused;

    assign w_awaddr = s_axi.s_awaddr;
    assign w_araddr = s_axi.s_araddr;
    assign w_unused = ^{s_axi.s_wdata[31:16], s_axi.s_wstrb[3:2],
                        w_awaddr[1:0], w_araddr[1:0]};

    // ---------------- write channel FSM ----------------
    always_ff @(posedge clk_100MHz) begin
        if (reset) r_wr_state <= WR_IDLE;
        else       r_wr_state <= w_wr_next;
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            WR_IDLE: if (r_aw_held && r_w_held) w_wr_next = WR_RESP;
            WR_RESP: if (s_axi.s_bready)        w_wr_next = WR_IDLE;
            default:                            w_wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                w_awready = ~r_aw_held & ~reset;
                w_wready  = ~r_w_held & ~reset;
            end
            WR_RESP: w_bvalid = 1'b1;
            default: ;
        endcase
    end

    assign w_aw_hs  = s_axi.s_awvalid & w_awready;
    assign w_w_hs   = s_axi.s_wvalid & w_wready;
    assign w_b_hs   = w_bvalid & s_axi.s_bready;
    assign w_commit = (r_wr_state == WR_IDLE) & r_aw_held & r_w_held;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
        end else if (w_b_hs) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
        end else begin
            if (w_aw_hs) r_aw_held <= 1'b1;
            if (w_w_hs)  r_w_held  <= 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (w_aw_hs) r_aw_idx <= w_awaddr[4:2];
        if (w_w_hs) begin
            r_wdata <= s_axi.s_wdata[15:0];
            r_wstrb <= s_axi.s_wstrb[1:0];
        end
    end

    // Decode of the held write; effects only land when w_commit is high
    always_comb begin
        w_wr_resp  = RESP_OKAY;
        w_push     = 1'b0;
        w_drop     = 1'b0;
        w_drop_clr = 1'b0;
        w_baud_we  = 1'b0;
        w_irqen_we = 1'b0;
        case (r_aw_idx)
            REG_TX_DATA: begin
                if (r_wstrb[0]) begin
                    if (tx_full) begin
                        w_drop    = 1'b1;
                        w_wr_resp = RESP_SLVERR;
                    end else begin
                        w_push    = 1'b1;
                    end
                end
            end
            REG_STATUS: w_drop_clr = r_wstrb[0] & r_wdata[ST_TX_DROP];
            REG_BAUD:   w_baud_we  = 1'b1;
`ifdef UART_AXIL_IRQ_EN
            REG_IRQ_EN: w_irqen_we = r_wstrb[0];
`endif
            default:    w_wr_resp  = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_bresp      <= RESP_OKAY;
            r_tx_drop    <= 1'b0;
            r_baud       <= 16'(BAUD_DEFAULT);
            r_write_uart <= 1'b0;
            r_write_data <= '0;
        end else begin
            r_write_uart <= w_commit & w_push;
            if (w_commit) begin
                r_bresp <= w_wr_resp;
                if (w_push)    r_write_data <= r_wdata[DBITS-1:0];
                if (w_baud_we) r_baud <= merge_bytes16(r_baud, r_wdata, r_wstrb);
            end
            // A drop outranks a clear landing on the same edge
            if (w_commit && w_drop)          r_tx_drop <= 1'b1;
            else if (w_commit && w_drop_clr) r_tx_drop <= 1'b0;
        end
    end

    // ---------------- read channel FSM ----------------
    always_ff @(posedge clk_100MHz) begin
        if (reset) r_rd_state <= RD_IDLE;
        else       r_rd_state <= w_rd_next;
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (s_axi.s_arvalid) w_rd_next = RD_DATA;
            RD_DATA: if (s_axi.s_rready)  w_rd_next = RD_IDLE;
            default:                      w_rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        case (r_rd_state)
            RD_IDLE: w_arready = ~reset;
            RD_DATA: w_rvalid  = 1'b1;
            default: ;
        endcase
    end

    assign w_ar_hs = s_axi.s_arvalid & w_arready;

    always_comb begin
        w_status              = '0;
        w_status[ST_RX_EMPTY] = rx_empty;
        w_status[ST_RX_FULL]  = rx_full;
        w_status[ST_TX_FULL]  = tx_full;
        w_status[ST_TX_DROP]  = r_tx_drop;
    end

    always_comb begin
        w_rd_val  = '0;
        w_rd_resp = RESP_OKAY;
        w_pop     = 1'b0;
        case (w_araddr[4:2])
            REG_RX_DATA: begin
                if (rx_empty) begin
                    w_rd_val = 32'h0000_0100;
                end else begin
                    w_rd_val = 32'(read_data);
                    w_pop    = 1'b1;
                end
            end
            REG_TX_DATA: w_rd_val = '0;
            REG_STATUS:  w_rd_val = w_status;
            REG_BAUD:    w_rd_val = {16'h0000, r_baud};
`ifdef UART_AXIL_IRQ_EN
            REG_IRQ_EN:  w_rd_val = {30'd0, w_irq_en};
`endif
            default:     w_rd_resp = RESP_SLVERR;
        endcase
    end

    // Pop is tied to the AR handshake, so a stalled rready cannot pop twice
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_rdata     <= '0;
            r_rresp     <= RESP_OKAY;
            r_read_uart <= 1'b0;
        end else begin
            r_read_uart <= w_ar_hs & w_pop;
            if (w_ar_hs) begin
                r_rdata <= w_rd_val;
                r_rresp <= w_rd_resp;
            end
        end
    end

    // ---------------- interrupt ----------------
`ifdef UART_AXIL_IRQ_EN
    logic [1:0] r_irq_en;
    logic       r_irq;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_irq_en <= 2'b00;
            r_irq    <= 1'b0;
        end else begin
            if (w_commit && w_irqen_we) r_irq_en <= r_wdata[1:0];
            r_irq <= (r_irq_en[0] & ~rx_empty) | (r_irq_en[1] & ~tx_full);
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    logic w_unused_irq;
    assign w_unused_irq = w_irqen_we;
    assign w_irq_en     = 2'b00;
    assign irq          = 1'b0;
`endif

    assign s_axi.s_awready = w_awready;
    assign s_axi.s_wready  = w_wready;
    assign s_axi.s_bvalid  = w_bvalid;
    assign s_axi.s_bresp   = r_bresp;
    assign s_axi.s_arready = w_arready;
    assign s_axi.s_rvalid  = w_rvalid;
    assign s_axi.s_rdata   = r_rdata;
    assign s_axi.s_rresp   = r_rresp;

    assign read_uart   = r_read_uart;
    assign write_uart  = r_write_uart;
    assign write_data  = r_write_data;
    assign br_limit_in = r_baud;

endmodule

// File: tb/tb_uart_axil_regs.sv
// Bench for uart_axil_regs: directed vector table, hand sequences, then random traffic vs a register-map model.
`timescale 1ns/1ps
module tb_uart_axil_regs;

    logic clk_100MHz = 1'b0;
    logic reset;
    always #5 clk_100MHz = ~clk_100MHz;

    uart_axil_regs_if #(.ADDR_W(5)) bus ();

    logic       rx_empty, rx_full, tx_full;
    logic [7:0] read_data;
    logic       read_uart, write_uart;
    logic [7:0] write_data;
    logic [15:0] br_limit_in;
    logic       irq;

    uart_axil_regs #(.ADDR_W(5), .DBITS(8), .BAUD_DEFAULT(651)) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .s_axi       (bus),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .tx_full     (tx_full),
        .read_data   (read_data),
        .read_uart   (read_uart),
        .write_uart  (write_uart),
        .write_data  (write_data),
        .br_limit_in (br_limit_in),
        .irq         (irq)
    );

`ifdef UART_AXIL_IRQ_EN
    localparam bit IRQ_PRESENT = 1'b1;
`else
    localparam bit IRQ_PRESENT = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    int push_cnt = 0;
    int pop_cnt  = 0;
    logic [7:0] last_push = 8'h00;

    always @(negedge clk_100MHz) begin
        if (write_uart === 1'b1) begin
            push_cnt++;
            last_push = write_data;
        end
        if (read_uart === 1'b1) pop_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model of the register file
    int unsigned m_baud;
    bit          m_drop;
    int unsigned m_irq_en;

    task automatic model_reset();
        m_baud = 651; m_drop = 0; m_irq_en = 0;
    endtask

    task automatic model_read(input int unsigned addr, output int unsigned d,
                              output int unsigned r, output int pops);
        int unsigned word;
        word = addr / 4; d = 0; r = 0; pops = 0;
        if (word == 0) begin
            if (rx_empty) d = 256;
            else begin d = read_data; pops = 1; end
        end else if (word == 1) d = 0;
        else if (word == 2) d = rx_empty + 2 * rx_full + 4 * tx_full + 8 * m_drop;
        else if (word == 3) d = m_baud;
        else if (word == 4 && IRQ_PRESENT) d = m_irq_en;
        else r = 2;
    endtask

    task automatic model_write(input int unsigned addr, input int unsigned d, input int unsigned strb,
                               output int unsigned r, output int pushes, output int unsigned byte_v);
        int unsigned word, lo, hi;
        word = addr / 4; r = 0; pushes = 0; byte_v = 0;
        if (word == 1) begin
            if (strb % 2 == 1) begin
                if (tx_full) begin m_drop = 1; r = 2; end
                else begin pushes = 1; byte_v = d % 256; end
            end
        end else if (word == 2) begin
            if (strb % 2 == 1 && (d / 8) % 2 == 1) m_drop = 0;
        end else if (word == 3) begin
            lo = (strb % 2 == 1)       ? d % 256         : m_baud % 256;
            hi = ((strb / 2) % 2 == 1) ? (d / 256) % 256 : m_baud / 256;
            m_baud = hi * 256 + lo;
        end else if (word == 4 && IRQ_PRESENT) begin
            if (strb % 2 == 1) m_irq_en = d % 4;
        end else r = 2;
    endtask

    function automatic int unsigned model_irq();
        int unsigned e0, e1;
        e0 = m_irq_en % 2; e1 = (m_irq_en / 2) % 2;
        return ((e0 == 1 && !rx_empty) || (e1 == 1 && !tx_full)) ? 1 : 0;
    endfunction

    // lead > 0: AW that many cycles before W; lead < 0: W first
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input bit hold_b, output logic [1:0] resp, output bit ok);
        bit aw_done, w_done, a_hs, w_hs;
        int aw_t, w_t;
        aw_done = 0; w_done = 0; ok = 0; resp = 2'b11;
        aw_t = (lead < 0) ? -lead : 0;
        w_t  = (lead > 0) ? lead : 0;
        bus.s_awaddr = addr; bus.s_wdata = data; bus.s_wstrb = strb;
        for (int t = 0; t < 40 && !(aw_done && w_done); t++) begin
            bus.s_awvalid = !aw_done && (t >= aw_t);
            bus.s_wvalid  = !w_done && (t >= w_t);
            @(negedge clk_100MHz);
            a_hs = bus.s_awvalid && bus.s_awready;
            w_hs = bus.s_wvalid && bus.s_wready;
            @(posedge clk_100MHz); #1;
            if (a_hs) aw_done = 1;
            if (w_hs) w_done = 1;
        end
        bus.s_awvalid = 0; bus.s_wvalid = 0;
        if (aw_done && w_done) begin
            for (int t = 0; t < 20; t++) begin
                @(negedge clk_100MHz);
                if (bus.s_bvalid) begin
                    resp = bus.s_bresp; ok = 1;
                    if (!hold_b) begin
                        bus.s_bready = 1;
                        @(posedge clk_100MHz); #1;
                        bus.s_bready = 0;
                    end
                    break;
                end
            end
        end
    endtask

    task automatic axi_read(input logic [4:0] addr, input int stall, output logic [31:0] data,
                            output logic [1:0] resp, output bit ok, output bit stable, output int lat);
        bit got;
        ok = 0; stable = 1; data = 32'hFFFF_FFFF; resp = 2'b11; got = 0; lat = -1;
        bus.s_araddr = addr; bus.s_arvalid = 1; bus.s_rready = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk_100MHz);
            got = bus.s_arready;
            @(posedge clk_100MHz); #1;
        end
        bus.s_arvalid = 0;
        if (got) begin
            for (int t = 0; t < 20; t++) begin
                @(negedge clk_100MHz);
                if (bus.s_rvalid) begin
                    data = bus.s_rdata; resp = bus.s_rresp; ok = 1; lat = t;
                    for (int s = 0; s < stall; s++) begin
                        @(negedge clk_100MHz);
                        if (!bus.s_rvalid || bus.s_rdata !== data) stable = 0;
                    end
                    bus.s_rready = 1;
                    @(posedge clk_100MHz); #1;
                    bus.s_rready = 0;
                    break;
                end
            end
        end
    endtask

    typedef struct {
        bit          is_wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          lead_stall;
        bit          rxe, rxf, txf;
        logic [7:0]  rbyte;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_pulses;
        logic [15:0] exp_baud;
    } vec_t;

    function automatic vec_t mk(bit w, logic [4:0] a, logic [31:0] d, logic [3:0] s, int ls,
                                bit rxe, bit rxf, bit txf, logic [7:0] rb,
                                logic [31:0] ed, logic [1:0] er, int ep, logic [15:0] eb);
        vec_t v;
        v.is_wr = w; v.addr = a; v.wdata = d; v.strb = s; v.lead_stall = ls;
        v.rxe = rxe; v.rxf = rxf; v.txf = txf; v.rbyte = rb;
        v.exp_data = ed; v.exp_resp = er; v.exp_pulses = ep; v.exp_baud = eb;
        return v;
    endfunction

    vec_t vecs[16];

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        bit          ok, stable;
        int          lat, p0, q0, pushes, pops;
        int unsigned md, mr, mb, addr, data, strb;

        vecs[0]  = mk(0, 5'h0C, 0,      4'hF, 0,  1, 0, 0, 8'h00, 32'h28B,  2'b00, 0, 16'h028B);
        vecs[1]  = mk(1, 5'h04, 32'h55, 4'hF, 3,  1, 0, 0, 8'h00, 32'h55,   2'b00, 1, 16'h028B);
        vecs[2]  = mk(1, 5'h04, 32'hAA, 4'hF, 0,  1, 0, 1, 8'h00, 32'h0,    2'b10, 0, 16'h028B);
        vecs[3]  = mk(0, 5'h08, 0,      4'hF, 0,  1, 0, 1, 8'h00, 32'hD,    2'b00, 0, 16'h028B);
        vecs[4]  = mk(1, 5'h08, 32'h8,  4'hF, -1, 1, 0, 1, 8'h00, 32'h0,    2'b00, 0, 16'h028B);
        vecs[5]  = mk(0, 5'h08, 0,      4'hF, 1,  1, 1, 0, 8'h00, 32'h3,    2'b00, 0, 16'h028B);
        vecs[6]  = mk(0, 5'h00, 0,      4'hF, 5,  0, 0, 0, 8'h3C, 32'h3C,   2'b00, 1, 16'h028B);
        vecs[7]  = mk(0, 5'h00, 0,      4'hF, 5,  1, 0, 0, 8'h3C, 32'h100,  2'b00, 0, 16'h028B);
        vecs[8]  = mk(1, 5'h0C, 32'h34, 4'h1, 0,  1, 0, 0, 8'h00, 32'h0,    2'b00, 0, 16'h0234);
        vecs[9]  = mk(0, 5'h14, 0,      4'hF, 0,  1, 0, 0, 8'h00, 32'h0,    2'b10, 0, 16'h0234);
        vecs[10] = mk(1, 5'h00, 32'h12, 4'hF, 0,  0, 0, 0, 8'h99, 32'h0,    2'b10, 0, 16'h0234);
        vecs[11] = mk(1, 5'h04, 32'h77, 4'h2, 2,  1, 0, 0, 8'h00, 32'h0,    2'b00, 0, 16'h0234);
        vecs[12] = mk(0, 5'h10, 0,      4'hF, 0,  1, 0, 0, 8'h00, 32'h0,
                      IRQ_PRESENT ? 2'b00 : 2'b10, 0, 16'h0234);
        vecs[13] = mk(0, 5'h04, 0,      4'hF, 0,  1, 0, 0, 8'h00, 32'h0,    2'b00, 0, 16'h0234);
        vecs[14] = mk(1, 5'h0C, 32'hABCD, 4'h3, -2, 1, 0, 0, 8'h00, 32'h0,  2'b00, 0, 16'hABCD);
        vecs[15] = mk(0, 5'h0C, 0,      4'hF, 2,  1, 0, 0, 8'h00, 32'hABCD, 2'b00, 0, 16'hABCD);

        bus.s_awaddr = 0; bus.s_awvalid = 0; bus.s_wdata = 0; bus.s_wstrb = 0; bus.s_wvalid = 0;
        bus.s_bready = 0; bus.s_araddr = 0; bus.s_arvalid = 0; bus.s_rready = 0;
        rx_empty = 1; rx_full = 0; tx_full = 0; read_data = 0;
        reset = 1;
        repeat (3) @(posedge clk_100MHz);
        #1;
        check("rst_awready", bus.s_awready, 0);
        check("rst_arready", bus.s_arready, 0);
        check("rst_bvalid", bus.s_bvalid, 0);
        check("rst_rvalid", bus.s_rvalid, 0);
        check("rst_rdata", bus.s_rdata, 0);
        check("rst_uart_pulses", {write_uart, read_uart}, 0);
        check("rst_write_data", write_data, 0);
        check("rst_baud", br_limit_in, 651);
        check("rst_irq", irq, 0);
        reset = 0;
        @(posedge clk_100MHz); #1;
        check("idle_ready", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b111);

        for (int i = 0; i < 16; i++) begin
            rx_empty = vecs[i].rxe; rx_full = vecs[i].rxf; tx_full = vecs[i].txf;
            read_data = vecs[i].rbyte;
            p0 = push_cnt; q0 = pop_cnt;
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].lead_stall, 0, rr, ok);
                check($sformatf("v%0d_wr_done", i), ok, 1);
                check($sformatf("v%0d_bresp", i), rr, vecs[i].exp_resp);
                check($sformatf("v%0d_pushes", i), push_cnt - p0, vecs[i].exp_pulses);
                if (vecs[i].exp_pulses == 1)
                    check($sformatf("v%0d_push_byte", i), last_push, vecs[i].exp_data);
            end else begin
                axi_read(vecs[i].addr, vecs[i].lead_stall, rd, rr, ok, stable, lat);
                check($sformatf("v%0d_rd_done", i), ok, 1);
                check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_data);
                check($sformatf("v%0d_rresp", i), rr, vecs[i].exp_resp);
                check($sformatf("v%0d_pops", i), pop_cnt - q0, vecs[i].exp_pulses);
                check($sformatf("v%0d_stable", i), stable, 1);
                check($sformatf("v%0d_latency", i), lat, 0);
            end
            check($sformatf("v%0d_baud", i), br_limit_in, vecs[i].exp_baud);
        end

        // Reset lands while a write response is still waiting for bready
        rx_empty = 1; tx_full = 0;
        axi_write(5'h0C, 32'h1111, 4'hF, 0, 1, rr, ok);
        check("hold_b_seen", ok, 1);
        check("hold_b_baud", br_limit_in, 16'h1111);
        @(posedge clk_100MHz); #1;
        check("hold_b_still", bus.s_bvalid, 1);
        reset = 1;
        @(posedge clk_100MHz); #1;
        check("rst_mid_bvalid", bus.s_bvalid, 0);
        check("rst_mid_baud", br_limit_in, 651);
        reset = 0;
        model_reset();
        @(posedge clk_100MHz); #1;
        check("post_rst_awready", bus.s_awready, 1);

`ifdef UART_AXIL_IRQ_EN
        rx_empty = 1; tx_full = 1;
        axi_write(5'h10, 32'h1, 4'hF, 0, 0, rr, ok);
        model_write(32'h10, 1, 15, mr, pushes, mb);
        check("irqen_bresp", rr, 0);
        repeat (2) @(posedge clk_100MHz);
        #1;
        check("irq_idle", irq, 0);
        rx_empty = 0;
        @(negedge clk_100MHz);
        check("irq_not_yet", irq, 0);
        @(posedge clk_100MHz); #1;
        check("irq_rise", irq, 1);
`endif

        for (int n = 0; n < 60; n++) begin
            rx_empty = $urandom_range(0, 1); rx_full = $urandom_range(0, 1);
            tx_full = $urandom_range(0, 1); read_data = 8'($urandom);
            addr = $urandom_range(0, 7) * 4;
            p0 = push_cnt; q0 = pop_cnt;
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom; strb = $urandom_range(0, 15);
                axi_write(5'(addr), data, 4'(strb), $urandom_range(0, 6) - 3, 0, rr, ok);
                model_write(addr, data, strb, mr, pushes, mb);
                check($sformatf("r%0d_wr_done", n), ok, 1);
                check($sformatf("r%0d_bresp@%0h", n, addr), rr, mr);
                check($sformatf("r%0d_pushes", n), push_cnt - p0, pushes);
                if (pushes == 1) check($sformatf("r%0d_push_byte", n), last_push, mb);
            end else begin
                axi_read(5'(addr), $urandom_range(0, 3), rd, rr, ok, stable, lat);
                model_read(addr, md, mr, pops);
                check($sformatf("r%0d_rd_done", n), ok, 1);
                check($sformatf("r%0d_rdata@%0h", n, addr), rd, md);
                check($sformatf("r%0d_rresp@%0h", n, addr), rr, mr);
                check($sformatf("r%0d_pops", n), pop_cnt - q0, pops);
                check($sformatf("r%0d_stable", n), stable, 1);
            end
            check($sformatf("r%0d_baud", n), br_limit_in, m_baud);
            check($sformatf("r%0d_irq", n), irq, model_irq());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
